// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// A bundle is one aligned pair of 32-bit instructions plus the address of the first one.
package fetch_pkg;

  localparam int FETCH_BYTES = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr0;
    logic [31:0] instr1;
  } fetch_bundle_t;

  // True when an incoming pc breaks the straight-line sequence or the 8-byte alignment.
  function automatic logic pc_out_of_seq(input logic [31:0] pc,
                                         input logic [31:0] last_pc,
                                         input logic        last_valid);
    logic misaligned;
    logic jumped;
    misaligned = (pc[2:0] != 3'b000);
    jumped     = last_valid && (pc != last_pc + 32'(FETCH_BYTES));
    return misaligned || jumped;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular queue of fetch bundles between the fetch stage and decode.
// Flush (branch redirect) empties it; seq_err latches any pc discontinuity until reset.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_instr0,
  input  logic [31:0]              fetch_instr1,
  input  logic                     flush,
  output logic                     stall,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_instr0,
  output logic [31:0]              dec_instr1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     seq_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_bundle_t mem [DEPTH];
  fetch_bundle_t head;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   last_pc;
  logic          last_pc_valid;
  logic          enq;
  logic          deq;

  // stall and dec_valid come only from the registered occupancy
  assign stall     = (count == CW'(DEPTH));
  assign dec_valid = (count != '0);

  assign enq = fetch_valid && !stall && !flush;
  assign deq = dec_valid && dec_ready && !flush;

  assign head       = mem[rd_ptr];
  assign dec_pc     = dec_valid ? head.pc     : 32'h0;
  assign dec_instr0 = dec_valid ? head.instr0 : 32'h0;
  assign dec_instr1 = dec_valid ? head.instr1 : 32'h0;

  // Storage is deliberately not reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_ptr] <= fetch_bundle_t'{pc: fetch_pc, instr0: fetch_instr0, instr1: fetch_instr1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      last_pc       <= 32'h0;
      last_pc_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      last_pc_valid <= 1'b0;
    end else begin
      // pointer width equals log2(DEPTH), so the increment wraps on its own
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
      if (enq) begin
        last_pc       <= fetch_pc;
        last_pc_valid <= 1'b1;
      end
    end
  end

  // Sticky across flush; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      seq_err <= 1'b0;
    else if (enq && pc_out_of_seq(fetch_pc, last_pc, last_pc_valid))
      seq_err <= 1'b1;
  end

endmodule
